rat_io_responder: RTL
=====================

# rat_io_responder

Peripheral-side responder for the RAT MCU port-mapped I/O bus. It decodes PORT_ID, and on IO_STRB latches OUT_PORT into board output registers (LEDs, seven-segment value, interrupt mask). Combinationally, it drives IN_PORT from synchronized switches, debounced buttons and interrupt status. It also generates the level interrupt request that feeds the MCU's INT_CU input, with sticky per-button pending flags cleared by write-1-to-clear.

## Interface
- DB_COUNT, 50000, consecutive stable cycles required before a debounced button changes state (≥2)
- DB_W, 16, width of each debounce counter (2^DB_W > DB_COUNT)

- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- PORT_ID  in  8  port address from MCU
- OUT_PORT  in  8  write data from MCU
- IO_STRB  in  1  write strobe from MCU, one cycle per OUT instruction
- IN_PORT  out  8  read data to MCU, combinational decode of PORT_ID
- INT  out  1  interrupt request to MCU (level)
- SWITCHES  in  8  asynchronous board switches
- BTN  in  4  asynchronous board buttons, active-high
- LEDS  out  8  LED register
- SSEG_VAL  out  8  seven-segment display value register

## Operation
- Port map (R = readable via IN_PORT, W = written on IO_STRB):
  - 0x20 R: synchronized SWITCHES
  - 0x21 R: {4'b0, db[3:0]} debounced buttons
  - 0x22 R: {4'b0, pend[3:0]}; W: write-1-to-clear pend
  - 0x23 R/W: {4'b0, mask[3:0]}; upper write bits ignored
  - 0x40 R/W: LEDS
  - 0x81 R/W: SSEG_VAL
- Unmapped reads return 0x00. Writes to unmapped or read-only ports (0x20, 0x21) are ignored. Reads have no side effects.
- Writes take effect at the rising edge where IO_STRB=1. PORT_ID and OUT_PORT are sampled at that same edge.
- SWITCHES and BTN each pass through a 2-FF synchronizer (s1→s2). Only s2 is used downstream.
- Debounce, per button i:
  - If s2[i]==db[i], cnt[i]<=0.
  - Else, if cnt[i]==DB_COUNT-1, then db[i]<=s2[i] and cnt[i]<=0.
  - Otherwise, cnt[i]<=cnt[i]+1.
- Pending set: at the edge where db[i] goes 0→1, pend[i]<=1. The release edge (1→0) sets nothing.
- Pending clear: a write to 0x22 with OUT_PORT[i]=1 clears pend[i]. If set and clear occur at the same edge, set wins and pend[i] ends at 1.
- INT = |(pend & mask), decoded from registers only, with no path from PORT_ID or IO_STRB. Pending flags accumulate while masked; unmasking an already-pending bit asserts INT.

## Timing
- Reset (RESET=1 at an edge): LEDS=0x00, SSEG_VAL=0x00, mask=0, pend=0, db=0, cnt=0, all synchronizers=0, INT=0. IN_PORT then reflects these zeroed sources.
- RESET has priority over IO_STRB and over debounce at the same edge. Reset mid-debounce discards the count, and the button must be stable for a full DB_COUNT again.
- Write latency: the register updates at the strobe edge and is visible on its output and via IN_PORT in the next cycle.
- Read latency: zero cycles. IN_PORT is valid the same cycle PORT_ID is valid, so the MCU captures it at the following edge.
- Button latency: BTN rising before edge e gives s2=1 after e+1 and db=1 after e+1+DB_COUNT. pend and INT are also high from that same edge.
- A glitch on s2 shorter than DB_COUNT cycles produces no change in db.
- Each button is independent, so simultaneous presses set multiple pend bits at one edge.

## Test plan
- Reset, then read all ports → 0x20 equals SWITCHES (after 2 cycles), 0x21/0x22/0x23/0x40/0x81 read 0x00, unmapped 0x55 reads 0x00, INT=0.
- IO_STRB with PORT_ID=0x40, OUT_PORT=0xA5 → LEDS=0xA5 next cycle and reads 0xA5. Writing 0x20 with OUT_PORT=0xFF leaves the switch read unchanged. IO_STRB=0 with PORT_ID=0x81 leaves SSEG_VAL at 0x00.
- DB_COUNT=4, mask=0x1, BTN[0] raised before edge 0 and held → db[0]=1 and INT=1 after edge 5, not earlier. A 3-cycle BTN[1] pulse leaves 0x21 at 0x01.
- With mask=0, press BTN[2] → 0x22 reads 0x04 and INT=0. Then write 0x23=0x04 → INT=1. Then write 0x22=0x04 → pend=0, INT=0.
- W1C write to 0x22=0x01 on the same edge that db[0] rises → pend[0]=1 and INT stays 1.
- Assert RESET while cnt[3]=2 with BTN[3] held → db[3] rises only DB_COUNT cycles after the synchronizer refills, and LEDS and mask return to 0.

Source files
------------

// File: rtl/rat_io_responder.sv
// Purpose : RAT MCU port-mapped I/O responder (switches, buttons, LEDs, 7-seg, interrupt).
// Latency : writes land at the IO_STRB edge; IN_PORT read decode is combinational.
// Backpres: none; every IO_STRB write is accepted in the cycle it is presented.
//
// Ports:
//   CLK, RESET           clock and synchronous active-high reset
//   PORT_ID, OUT_PORT    MCU port address and write data
//   IO_STRB              one-cycle write strobe per OUT instruction
//   IN_PORT              read data for the addressed port
//   INT                  level interrupt request, |(pend & mask)
//   SWITCHES, BTN        asynchronous board inputs (BTN active-high)
//   LEDS, SSEG_VAL       board output registers
module rat_io_responder #(
    parameter int DB_COUNT = 50000,
    parameter int DB_W     = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       INT,
    input  logic [7:0] SWITCHES,
    input  logic [3:0] BTN,
    output logic [7:0] LEDS,
    output logic [7:0] SSEG_VAL
);

    localparam logic [7:0] PORT_SW   = 8'h20;
    localparam logic [7:0] PORT_BTN  = 8'h21;
    localparam logic [7:0] PORT_PEND = 8'h22;
    localparam logic [7:0] PORT_MASK = 8'h23;
    localparam logic [7:0] PORT_LEDS = 8'h40;
    localparam logic [7:0] PORT_SSEG = 8'h81;

    // Count value at which the next mismatching cycle commits the new level.
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_COUNT - 1);

    logic [7:0]      sw_s1;
    logic [7:0]      sw_s2;
    logic [3:0]      btn_s1;
    logic [3:0]      btn_s2;
    logic [3:0]      db;
    logic [3:0]      db_nxt;
    logic [DB_W-1:0] cnt     [4];
    logic [DB_W-1:0] cnt_nxt [4];
    logic [3:0]      pend;
    logic [3:0]      pend_set;
    logic [3:0]      pend_clr;
    logic [3:0]      mask;
    logic [7:0]      leds_q;
    logic [7:0]      sseg_q;

    // Two-flop synchronizers; only the second stage is used downstream.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= SWITCHES;
            sw_s2  <= sw_s1;
            btn_s1 <= BTN;
            btn_s2 <= btn_s1;
        end
    end

    // Debounce: the counter runs only while the synchronized input disagrees
    // with the debounced level, and any agreeing cycle restarts it from zero.
    always_comb begin
        db_nxt = db;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = '0;
            if (btn_s2[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_nxt[i] = btn_s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            db <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            db <= db_nxt;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Press edges of the debounced level set pending; release sets nothing.
    assign pend_set = db_nxt & ~db;
    assign pend_clr = (IO_STRB && (PORT_ID == PORT_PEND)) ? OUT_PORT[3:0] : 4'b0000;

    // Set is OR-ed in after the clear so a simultaneous press survives the W1C.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | pend_set;
        end
    end

    // Writable registers; writes to read-only or unmapped ports fall through.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mask   <= '0;
            leds_q <= '0;
            sseg_q <= '0;
        end else if (IO_STRB) begin
            case (PORT_ID)
                PORT_MASK: mask   <= OUT_PORT[3:0];
                PORT_LEDS: leds_q <= OUT_PORT;
                PORT_SSEG: sseg_q <= OUT_PORT;
                default:   ;
            endcase
        end
    end

    // Read mux: pure decode, no side effects.
    always_comb begin
        IN_PORT = 8'h00;
        case (PORT_ID)
            PORT_SW:   IN_PORT = sw_s2;
            PORT_BTN:  IN_PORT = {4'b0000, db};
            PORT_PEND: IN_PORT = {4'b0000, pend};
            PORT_MASK: IN_PORT = {4'b0000, mask};
            PORT_LEDS: IN_PORT = leds_q;
            PORT_SSEG: IN_PORT = sseg_q;
            default:   IN_PORT = 8'h00;
        endcase
    end

    // Interrupt depends on registered state only.
    assign INT      = |(pend & mask);
    assign LEDS     = leds_q;
    assign SSEG_VAL = sseg_q;

endmodule
